mips_int_ctrl: RTL and testbench
================================

MIPS_INT_CTRL -- requirements
Module: mips_int_ctrl

Interface
REQ-001 Parameter N_SRC, default 4, number of external interrupt sources (2..8).
REQ-002 Parameter ID_W, default $clog2(N_SRC), width of the interrupt ID.
REQ-003 i_clk  in  1  single clock; all state changes on its rising edge.
REQ-004 i_rst  in  1  synchronous, active-high reset.
REQ-005 i_irq  in  N_SRC  raw external interrupt lines; asynchronous; a rising edge requests service.
REQ-006 i_mask_we  in  1  mask write strobe.
REQ-007 i_mask_wdata  in  N_SRC  new mask value; bit=1 enables the source.
REQ-008 i_ack  in  1  CPU accepted the interrupt (exception entry), one-cycle pulse.
REQ-009 i_eoi  in  1  CPU finished service (eret), one-cycle pulse.
REQ-010 o_ext_int  out  1  interrupt request to the pipelined CPU's i_ext_int input; registered.
REQ-011 o_int_id  out  ID_W  index of the requested/in-service source; registered.
REQ-012 o_pending  out  N_SRC  pending register.
REQ-013 o_mask  out  N_SRC  mask register.

Function
REQ-014 Edge detect: edge[i] = s[i] & ~prev[i], where s is the sampled line and prev is s delayed one clock.
REQ-015 pending[i] is set on edge[i], regardless of mask; masked pending bits are retained.
REQ-016 Eligible = pending & mask; the lowest index has the highest priority.
REQ-017 FSM states: IDLE, REQ, SERVICE.
REQ-018 IDLE: any eligible bit -> REQ; o_int_id latches the winning index on the same edge.
REQ-019 REQ: o_ext_int = 1; on i_ack -> SERVICE and clear pending[o_int_id].
REQ-020 REQ: if mask[o_int_id] goes 0 without i_ack, withdraw -> IDLE (o_ext_int drops; pending kept).
REQ-021 SERVICE: o_ext_int = 0, no nesting; on i_eoi -> IDLE; the next request is issued one clock later at the earliest.
REQ-022 i_ack outside REQ and i_eoi outside SERVICE are ignored.
REQ-023 A set (edge) and a clear (ack) of the same pending bit in the same cycle: the set wins.
REQ-024 i_mask_we updates the mask on the next edge; the new mask applies to eligibility from that cycle on.
REQ-025 Latency, first clock edge k sampling i_irq high while idle: with INT_CTRL_SYNC_EN, pending set at k+2 and o_ext_int high after k+3; without it, pending set at k and o_ext_int high after k+1.
REQ-026 A line held high produces exactly one request; the line must fall and rise again to produce another.

Reset
REQ-027 i_rst while high forces: state IDLE, o_ext_int 0, o_int_id 0, pending 0, mask all-ones, synchronizer and prev flops 0.
REQ-028 Reset mid-REQ or mid-SERVICE abandons the request; no ack or eoi is expected afterwards.
REQ-029 A line already high when reset is released is detected as one edge.

Configuration
REQ-030 Macro INT_CTRL_SYNC_EN defined: each i_irq passes a 2-flop synchronizer before edge detection.
REQ-031 Macro INT_CTRL_SYNC_EN undefined: i_irq feeds edge detection directly (synchronous sources only); latency per REQ-025.

Structure
REQ-032 Package mips_int_pkg holds the FSM state enum (IDLE/REQ/SERVICE) and the N_SRC default constant.
REQ-033 Sub-module int_sync (N-bit, 2-flop, sync-reset synchronizer), instantiated only under INT_CTRL_SYNC_EN.

Verification
REQ-034 Reset, then i_irq=4'b0100 rising at k -> pending=4'b0100 at k+2, o_ext_int=1, o_int_id=2 after k+3 (sync build).
REQ-035 Edges on lines 3 and 1 in the same cycle -> id 1 requested first; ack, eoi -> id 3 requested next, one clock after eoi.
REQ-036 In REQ with id 0, write mask=4'b1110 -> o_ext_int=0 next cycle, pending[0] stays 1; restore mask -> request reissued.
REQ-037 New edge on the acked source in the same cycle as i_ack -> pending bit remains 1 after the ack.
REQ-038 i_rst pulsed during SERVICE -> all outputs return to reset values, mask=4'b1111; i_irq held high through release -> exactly one request.
REQ-039 Non-sync build, i_irq[0] rising at k -> o_ext_int=1 after k+1; i_irq[0] held high for 10 cycles -> only one pending set.

Source files
------------

// File: rtl/mips_int_pkg.sv
// Shared definitions for the MIPS external interrupt controller.
package mips_int_pkg;

    // Number of external interrupt sources when the parent does not override it.
    localparam int N_SRC_DEFAULT = 4;

    // Controller states: waiting, requesting the CPU, CPU servicing a source.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } int_state_t;

endpackage

// File: rtl/int_sync.sv
// N-bit two-flop synchronizer with synchronous active-high reset.
module int_sync #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] meta;

    // Two back-to-back flops give the first stage a full cycle to resolve metastability.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            meta <= '0;
            o_q  <= '0;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule

// File: rtl/mips_int_ctrl.sv
// External interrupt controller for the pipelined MIPS CPU.
// Edge-triggered sources latch into a pending register, are filtered by a
// mask and arbitrated lowest-index-first; one request is in flight at a time.
// Define INT_CTRL_SYNC_EN to pass i_irq through a 2-flop synchronizer
// (asynchronous sources); without it i_irq must be synchronous to i_clk.
module mips_int_ctrl
    import mips_int_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEFAULT,
    parameter int ID_W  = $clog2(N_SRC)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_SRC-1:0] i_irq,
    input  logic             i_mask_we,
    input  logic [N_SRC-1:0] i_mask_wdata,
    input  logic             i_ack,
    input  logic             i_eoi,
    output logic             o_ext_int,
    output logic [ID_W-1:0]  o_int_id,
    output logic [N_SRC-1:0] o_pending,
    output logic [N_SRC-1:0] o_mask
);

    int_state_t       state;
    int_state_t       state_next;
    logic [ID_W-1:0]  id_next;
    logic [ID_W-1:0]  win_id;
    logic [N_SRC-1:0] irq_s;
    logic [N_SRC-1:0] irq_prev;
    logic [N_SRC-1:0] irq_edge;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] clear_vec;
    logic [N_SRC-1:0] pending_next;

`ifdef INT_CTRL_SYNC_EN
    int_sync #(
        .WIDTH (N_SRC)
    ) u_int_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_irq),
        .o_q   (irq_s)
    );
`else
    assign irq_s = i_irq;
`endif

    // Previous sampled level; reset to 0 so a line high at reset release counts as one edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            irq_prev <= '0;
        end else begin
            irq_prev <= irq_s;
        end
    end

    assign irq_edge = irq_s & ~irq_prev;
    assign eligible = pending & mask;

    // Lowest eligible index wins; scanning downward leaves the lowest hit last.
    always_comb begin
        win_id = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_id = ID_W'(i);
            end
        end
    end

    // Next state, latched ID and the pending bit to clear on acknowledge.
    always_comb begin
        state_next = state;
        id_next    = o_int_id;
        clear_vec  = '0;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    state_next = REQ;
                    id_next    = win_id;
                end
            end
            REQ: begin
                if (i_ack) begin
                    state_next          = SERVICE;
                    clear_vec[o_int_id] = 1'b1;
                end else if (!mask[o_int_id]) begin
                    state_next = IDLE;
                end
            end
            SERVICE: begin
                if (i_eoi) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A fresh edge is ORed in after the clear so a simultaneous set wins.
    assign pending_next = (pending & ~clear_vec) | irq_edge;

    // State, latched ID and the registered request line to the CPU.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            o_int_id  <= '0;
            o_ext_int <= 1'b0;
        end else begin
            state     <= state_next;
            o_int_id  <= id_next;
            o_ext_int <= (state_next == REQ);
        end
    end

    // Pending bits are kept regardless of mask; mask resets to all sources enabled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pending <= '0;
            mask    <= '1;
        end else begin
            pending <= pending_next;
            if (i_mask_we) begin
                mask <= i_mask_wdata;
            end
        end
    end

    assign o_pending = pending;
    assign o_mask    = mask;

endmodule

// File: tb/tb_mips_int_ctrl.sv
// Directed self-checking bench for mips_int_ctrl (N_SRC = 4).
// Expected timing follows the build: INT_CTRL_SYNC_EN adds two cycles of latency.
module tb_mips_int_ctrl;

`ifdef INT_CTRL_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       i_clk;
    logic       i_rst;
    logic [3:0] i_irq;
    logic       i_mask_we;
    logic [3:0] i_mask_wdata;
    logic       i_ack;
    logic       i_eoi;
    logic       o_ext_int;
    logic [1:0] o_int_id;
    logic [3:0] o_pending;
    logic [3:0] o_mask;

    int tests_run    = 0;
    int tests_failed = 0;

    mips_int_ctrl #(
        .N_SRC (4),
        .ID_W  (2)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_irq        (i_irq),
        .i_mask_we    (i_mask_we),
        .i_mask_wdata (i_mask_wdata),
        .i_ack        (i_ack),
        .i_eoi        (i_eoi),
        .o_ext_int    (o_ext_int),
        .o_int_id     (o_int_id),
        .o_pending    (o_pending),
        .o_mask       (o_mask)
    );

    // Free-running 10 ns clock.
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    // Drive one cycle of inputs across one rising edge, then drop the strobes.
    task automatic applyStimulus(input logic [3:0] irq, input logic ack, input logic eoi,
                                 input logic we, input logic [3:0] wdata);
        i_irq        = irq;
        i_ack        = ack;
        i_eoi        = eoi;
        i_mask_we    = we;
        i_mask_wdata = wdata;
        @(posedge i_clk);
        #1;
        i_ack     = 1'b0;
        i_eoi     = 1'b0;
        i_mask_we = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        i_rst        = 1'b1;
        i_irq        = 4'b0000;
        i_mask_we    = 1'b0;
        i_mask_wdata = 4'b0000;
        i_ack        = 1'b0;
        i_eoi        = 1'b0;

        // Reset values.
        idle(3);
        checkOutput("rst_ext_int", 32'(o_ext_int), 32'd0);
        checkOutput("rst_int_id", 32'(o_int_id), 32'd0);
        checkOutput("rst_pending", 32'(o_pending), 32'b0000);
        checkOutput("rst_mask", 32'(o_mask), 32'b1111);
        i_rst = 1'b0;
        idle(2);

        // Single source 2: latency, then one request for a line held high.
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0, 4'b0000);
        idle(LAT);
        checkOutput("a_pending_set", 32'(o_pending), 32'b0100);
        checkOutput("a_ext_not_yet", 32'(o_ext_int), 32'd0);
        idle(1);
        checkOutput("a_ext_int", 32'(o_ext_int), 32'd1);
        checkOutput("a_int_id", 32'(o_int_id), 32'd2);
        idle(9);
        applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000);
        checkOutput("a_ext_after_ack", 32'(o_ext_int), 32'd0);
        checkOutput("a_pending_after_ack", 32'(o_pending), 32'b0000);
        idle(8);
        checkOutput("a_pending_held_line", 32'(o_pending), 32'b0000);
        applyStimulus(4'b0100, 1'b0, 1'b1, 1'b0, 4'b0000);
        idle(3);
        checkOutput("a_no_second_req", 32'(o_ext_int), 32'd0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
        idle(LAT + 2);

        // Lines 3 and 1 together: 1 first, then 3 one clock after eoi.
        applyStimulus(4'b1010, 1'b0, 1'b0, 1'b0, 4'b0000);
        idle(LAT);
        checkOutput("b_pending_both", 32'(o_pending), 32'b1010);
        idle(1);
        checkOutput("b_ext_first", 32'(o_ext_int), 32'd1);
        checkOutput("b_id_first", 32'(o_int_id), 32'd1);
        applyStimulus(4'b1010, 1'b1, 1'b0, 1'b0, 4'b0000);
        checkOutput("b_ext_service", 32'(o_ext_int), 32'd0);
        checkOutput("b_pending_after_ack", 32'(o_pending), 32'b1000);
        applyStimulus(4'b1010, 1'b0, 1'b1, 1'b0, 4'b0000);
        checkOutput("b_ext_at_eoi", 32'(o_ext_int), 32'd0);
        idle(1);
        checkOutput("b_ext_second", 32'(o_ext_int), 32'd1);
        checkOutput("b_id_second", 32'(o_int_id), 32'd3);
        applyStimulus(4'b1010, 1'b1, 1'b0, 1'b0, 4'b0000);
        checkOutput("b_pending_cleared", 32'(o_pending), 32'b0000);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000);
        idle(LAT + 2);

        // Masking the requested source withdraws the request; unmask reissues it.
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000);
        idle(LAT + 1);
        checkOutput("c_ext_id0", 32'(o_ext_int), 32'd1);
        checkOutput("c_id0", 32'(o_int_id), 32'd0);
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b1, 4'b1110);
        checkOutput("c_mask_written", 32'(o_mask), 32'b1110);
        idle(1);
        checkOutput("c_ext_withdrawn", 32'(o_ext_int), 32'd0);
        checkOutput("c_pending_kept", 32'(o_pending), 32'b0001);
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b1, 4'b1111);
        checkOutput("c_mask_restored", 32'(o_mask), 32'b1111);
        idle(1);
        checkOutput("c_ext_reissued", 32'(o_ext_int), 32'd1);
        checkOutput("c_id_reissued", 32'(o_int_id), 32'd0);
        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, 4'b0000);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000);
        idle(LAT + 2);

        // New edge on the acked source in the ack cycle keeps its pending bit.
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0, 4'b0000);
        idle(LAT + 1);
        checkOutput("d_ext_id2", 32'(o_ext_int), 32'd1);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
        i_irq = 4'b0100;
        idle(LAT);
        applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000);
        checkOutput("d_pending_set_wins", 32'(o_pending), 32'b0100);
        checkOutput("d_ext_service", 32'(o_ext_int), 32'd0);
        applyStimulus(4'b0100, 1'b0, 1'b1, 1'b0, 4'b0000);
        idle(1);
        checkOutput("d_ext_again", 32'(o_ext_int), 32'd1);
        checkOutput("d_id_again", 32'(o_int_id), 32'd2);

        // Reset during SERVICE with the line held high through release.
        applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000);
        checkOutput("e_pending_service", 32'(o_pending), 32'b0000);
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b1, 4'b0110);
        checkOutput("e_mask_custom", 32'(o_mask), 32'b0110);
        i_rst = 1'b1;
        idle(2);
        checkOutput("e_rst_ext_int", 32'(o_ext_int), 32'd0);
        checkOutput("e_rst_int_id", 32'(o_int_id), 32'd0);
        checkOutput("e_rst_pending", 32'(o_pending), 32'b0000);
        checkOutput("e_rst_mask", 32'(o_mask), 32'b1111);
        i_rst = 1'b0;
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0, 4'b0000);
        idle(LAT);
        checkOutput("e_pending_after_rst", 32'(o_pending), 32'b0100);
        idle(1);
        checkOutput("e_ext_after_rst", 32'(o_ext_int), 32'd1);
        checkOutput("e_id_after_rst", 32'(o_int_id), 32'd2);
        applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000);
        idle(6);
        checkOutput("e_single_pending", 32'(o_pending), 32'b0000);
        checkOutput("e_single_ext", 32'(o_ext_int), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
